// File: rtl/gol_tga_streamer.sv
// Game of Life frame renderer: snapshots the grid on a start edge and streams
// an uncompressed 24-bit TGA image (optional header + BGR pixels) over valid/ready.
module gol_tga_streamer #(
    parameter int          GRID_W    = 8,
    parameter int          GRID_H    = 8,
    parameter int          SCALE     = 1,
    parameter logic [23:0] ALIVE_RGB = 24'hFFFFFF,
    parameter logic [23:0] DEAD_RGB  = 24'h000000,
    parameter bit          HEADER_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [GRID_W*GRID_H-1:0] grid,
    output logic [7:0]               tdata,
    output logic                     tvalid,
    input  logic                     tready,
    output logic                     tlast,
    output logic                     busy,
    output logic [15:0]              frame_cnt,
    output logic [7:0]               drop_cnt
);
    localparam int N  = GRID_W * GRID_H;
    localparam int W  = GRID_W * SCALE;
    localparam int H  = GRID_H * SCALE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [15:0] W16 = 16'(W);
    localparam logic [15:0] H16 = 16'(H);

    if (W > 65535 || H > 65535 || SCALE < 1 || SCALE > 16) begin : g_bad_size
        $error("gol_tga_streamer: image dimensions or SCALE out of range");
    end

    typedef enum logic [1:0] {IDLE, HEADER, PIXEL} state_t;

    state_t          state, n_state;
    logic            start_q;
    logic [N-1:0]    snap;
    logic [4:0]      hidx, n_hidx;
    logic [1:0]      bsel, n_bsel;
    logic [SW-1:0]   sx, sy, n_sx, n_sy;
    logic [XW-1:0]   cx, n_cx;
    logic [CW-1:0]   cidx, rowbase, n_cidx, n_rowbase;
    logic [7:0]      n_byte;
    logic            n_last;
    logic            start_edge, xfer;

    assign start_edge = start & ~start_q;
    assign xfer       = tvalid & tready;

    function automatic logic [7:0] hdr_byte(input logic [4:0] i);
        case (i)
            5'd2:    return 8'h02;
            5'd12:   return W16[7:0];
            5'd13:   return W16[15:8];
            5'd14:   return H16[7:0];
            5'd15:   return H16[15:8];
            5'd16:   return 8'h18;
            5'd17:   return 8'h20;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] pix_byte(input logic alive, input logic [1:0] b);
        logic [23:0] c;
        c = alive ? ALIVE_RGB : DEAD_RGB;
        case (b)
            2'd0:    return c[7:0];
            2'd1:    return c[15:8];
            default: return c[23:16];
        endcase
    endfunction

    // Position of the byte following the one currently presented on tdata.
    // cidx walks cells; at a row end it either replays the row (sy) or advances.
    always_comb begin
        n_state   = state;
        n_hidx    = hidx;
        n_bsel    = bsel;
        n_sx      = sx;
        n_sy      = sy;
        n_cx      = cx;
        n_cidx    = cidx;
        n_rowbase = rowbase;
        case (state)
            HEADER: begin
                if (hidx == 5'd17) n_state = PIXEL;
                else               n_hidx  = hidx + 5'd1;
            end
            PIXEL: begin
                if (bsel != 2'd2) begin
                    n_bsel = bsel + 2'd1;
                end else begin
                    n_bsel = 2'd0;
                    if (sx != SW'(SCALE-1)) begin
                        n_sx = sx + SW'(1);
                    end else begin
                        n_sx = '0;
                        if (cx != XW'(GRID_W-1)) begin
                            n_cx   = cx + XW'(1);
                            n_cidx = cidx + CW'(1);
                        end else begin
                            n_cx = '0;
                            if (sy != SW'(SCALE-1)) begin
                                n_sy   = sy + SW'(1);
                                n_cidx = rowbase;
                            end else begin
                                n_sy      = '0;
                                n_rowbase = rowbase + CW'(GRID_W);
                                n_cidx    = rowbase + CW'(GRID_W);
                            end
                        end
                    end
                end
            end
            default: ;
        endcase
        n_byte = (n_state == HEADER) ? hdr_byte(n_hidx) : pix_byte(snap[n_cidx], n_bsel);
        n_last = (n_state == PIXEL) && (n_bsel == 2'd2) && (n_cidx == CW'(N-1)) &&
                 (n_sx == SW'(SCALE-1)) && (n_sy == SW'(SCALE-1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            snap      <= '0;
            hidx      <= '0;
            bsel      <= '0;
            sx        <= '0;
            sy        <= '0;
            cx        <= '0;
            cidx      <= '0;
            rowbase   <= '0;
            tdata     <= 8'h00;
            tvalid    <= 1'b0;
            tlast     <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= 16'd0;
            drop_cnt  <= 8'd0;
        end else begin
            start_q <= start;
            if (state == IDLE) begin
                if (start_edge) begin
                    snap    <= grid;
                    busy    <= 1'b1;
                    tvalid  <= 1'b1;
                    tlast   <= 1'b0;
                    hidx    <= '0;
                    bsel    <= '0;
                    sx      <= '0;
                    sy      <= '0;
                    cx      <= '0;
                    cidx    <= '0;
                    rowbase <= '0;
                    // Snapshot is not yet loaded, so a headerless first byte comes from grid.
                    if (HEADER_EN) begin
                        state <= HEADER;
                        tdata <= 8'h00;
                    end else begin
                        state <= PIXEL;
                        tdata <= pix_byte(grid[0], 2'd0);
                    end
                end
            end else begin
                if (start_edge && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                if (xfer) begin
                    if (tlast) begin
                        state     <= IDLE;
                        tvalid    <= 1'b0;
                        tlast     <= 1'b0;
                        busy      <= 1'b0;
                        frame_cnt <= frame_cnt + 16'd1;
                    end else begin
                        state   <= n_state;
                        hidx    <= n_hidx;
                        bsel    <= n_bsel;
                        sx      <= n_sx;
                        sy      <= n_sy;
                        cx      <= n_cx;
                        cidx    <= n_cidx;
                        rowbase <= n_rowbase;
                        tdata   <= n_byte;
                        tlast   <= n_last;
                    end
                end
            end
        end
    end
endmodule

// File: doc/gol_tga_streamer.md
Name: gol_tga_streamer

Overview:
- Synthesizable successor to the testbench TGA renderer. It snapshots the Game of Life grid on each generation update and streams a complete uncompressed 24-bit TGA image as a byte stream with a valid/ready handshake.
- Generalised over grid width/height, integer pixel scaling, cell colours and optional header emission.
- Sits between the gameoflife controller (grid + updatesignal) and a file/UART/DMA sink.

Parameters:
- GRID_W, 8, cells per row
- GRID_H, 8, cells per column
- SCALE, 1, output pixels per cell edge (1..16); each cell is rendered as a SCALE x SCALE block
- ALIVE_RGB, 24'hFFFFFF, colour of a live cell, {R,G,B}
- DEAD_RGB, 24'h000000, colour of a dead cell, {R,G,B}
- HEADER_EN, 1, 1 = prefix the 18-byte TGA header; 0 = raw BGR pixels only

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame request; connect to updatesignal (level or pulse; rising edge detected internally)
- grid  in  GRID_W*GRID_H  cell states; cell (x,y) is at bit x+y*GRID_W, 1 = alive
- tdata  out  8  stream byte
- tvalid  out  1  tdata is valid
- tready  in  1  sink accepts the byte this cycle
- tlast  out  1  marks the final byte of the frame
- busy  out  1  frame in progress
- frame_cnt  out  16  frames completed, wraps at 2^16
- drop_cnt  out  8  start edges ignored while busy, saturates at 255

Behaviour:
- Reset (async assert, sync deassert by the user):
  - tvalid=0, tlast=0, tdata=0, busy=0, frame_cnt=0, drop_cnt=0.
  - State = IDLE; edge detector history = 0; counters cleared.
  - Asserting reset mid-frame aborts the frame immediately. No tlast is emitted.
- Start edge: start_q registered each clk; edge = start & ~start_q.
- States:
  - IDLE -> (edge) HEADER if HEADER_EN, else PIXEL.
  - HEADER -> PIXEL after byte 17 transfers.
  - PIXEL -> IDLE after the final byte transfers.
  - On the edge cycle, grid is copied into an internal snapshot register. Output always uses the snapshot, so grid may change freely mid-frame.
  - busy=1 from the cycle after the edge until the cycle after the final transfer.
  - Edges seen while not IDLE (including the final-transfer cycle) are dropped and drop_cnt increments.
- Handshake:
  - A transfer occurs on a clk edge with tvalid&tready.
  - While tvalid=1 and tready=0, tdata and tlast hold stable.
  - tvalid never drops without a transfer, except on reset.
  - First tvalid rises 1 cycle after the edge. With tready=1 continuously, one byte is transferred per cycle with no bubbles.
- Header bytes, index 0..17:
  - 00 00 02 00 00 00 00 00 00 00 00 00
  - then Wlo Whi Hlo Hhi 18h 20h
  - where W=GRID_W*SCALE and H=GRID_H*SCALE, each 16-bit little-endian. Descriptor 20h = top-left origin.
- Pixel order:
  - Rows top to bottom (py=0..H-1), pixels left to right (px=0..W-1).
  - Cell = (px/SCALE, py/SCALE). Divides are implemented as sub-counters (sx, sy), not dividers.
  - Each pixel is 3 bytes in B,G,R order, taken from ALIVE_RGB or DEAD_RGB.
- tlast=1 only on byte R of pixel (W-1,H-1).
- Frame length = 18*HEADER_EN + 3*W*H bytes.
- frame_cnt increments on the final transfer.
- W and H must be <= 65535 (elaboration assertion).

Test Plan:
- GRID 2x2, SCALE=1, grid=4'b1001, tready=1, one start pulse:
  - bytes 0..17 = 00 00 02 00 00 00 00 00 00 00 00 00 02 00 02 00 18 20
  - then FF FF FF, 00 00 00, 00 00 00, FF FF FF
  - tlast on byte 29; frame_cnt=1; busy low after.
- Same setup, tready toggling 1010 plus random 30% stalls:
  - identical 30-byte sequence; tdata/tlast stable across every stall; no duplicates or losses.
- SCALE=2, GRID 2x2, grid=4'b0001, HEADER_EN=0:
  - 48 bytes; pixels (0,0),(1,0),(0,1),(1,1) white, all others black.
- Second start edge at byte 5 of a frame, and a grid change at byte 5:
  - drop_cnt=1; frame contents match the original snapshot; next start after completion produces the new grid.
- Reset pulsed at byte 10:
  - tvalid=0 immediately, busy=0, counters 0, no tlast.
  - A new start then yields a full, correct frame from header byte 0.
- 300 edges while busy:
  - drop_cnt saturates at 255.
- 65536 frames:
  - frame_cnt wraps to 0.
